// File: rtl/mcu_pkg.sv
// Shared MCU definitions: PC width, default reset vector,
// PC sequencer FSM states and a modulo-256 increment helper.
package mcu_pkg;

    localparam int PC_W = 8;

    localparam logic [PC_W-1:0] PC_RESET_VEC = 8'h00;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Wraps 8'hFF -> 8'h00 silently.
    function automatic pc_t pc_inc(input pc_t v);
        return v + pc_t'(1);
    endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for pc_unit (built only with PC_STACK_EN).
// Ports: clk, rst_n (async low), push/pop requests, push_data,
//        top (current top entry), full, empty.
module pc_stack
    import mcu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  pc_t  push_data,
    output pc_t  top,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    pc_t           mem_q [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] sel_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = cnt_q[AW-1:0];
    assign top_idx = cnt_q[AW-1:0] - AW'(1);
    assign top     = mem_q[top_idx];

    // Simultaneous push+pop replaces the top entry in place.
    assign sel_idx = do_pop ? top_idx : wr_idx;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[sel_idx] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter sequencer: BOOT/RUN/HALT FSM, jump/call/return.
// Ports: clk, rst_n (async low), en, load, load_addr, call, ret,
//        halt, resume -> pc, pc_1, running, stack_ovf, stack_unf.
// Macro PC_STACK_EN builds the return stack; without it call acts
// as load, ret as increment and the overflow flags read 0.
module pc_unit
    import mcu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC   = PC_RESET_VEC,
    parameter int              STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    input  logic            call,
    input  logic            ret,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_1,
    output logic            running,
    output logic            stack_ovf,
    output logic            stack_unf
);

    pc_state_e state_q;
    pc_state_e state_d;
    pc_t       pc_q;
    pc_t       pc_d;
    logic      advance;
    logic      sel_ret;
    logic      sel_call;
    logic      sel_load;

    assign pc      = pc_q;
    assign pc_1    = pc_inc(pc_q);
    assign running = (state_q == ST_RUN);

    // A halt request freezes the PC in the same cycle it is seen.
    assign advance  = running && !halt && en;
    assign sel_ret  = advance && ret;
    assign sel_call = advance && call && !ret;
    assign sel_load = advance && load && !ret && !call;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume && !halt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

`ifdef PC_STACK_EN
    pc_t  stk_top;
    logic stk_full;
    logic stk_empty;
    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;

    pc_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sel_call),
        .pop       (sel_ret),
        .push_data (pc_1),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q | (sel_call & stk_full);
        unf_d = unf_q | (sel_ret & stk_empty);
        if (sel_ret) begin
            pc_d = stk_empty ? pc_1 : stk_top;
        end else if (sel_call || sel_load) begin
            pc_d = load_addr;
        end else if (advance) begin
            pc_d = pc_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    // ret falls through to the plain increment branch.
    always_comb begin
        pc_d = pc_q;
        if (sel_call || sel_load) begin
            pc_d = load_addr;
        end else if (advance) begin
            pc_d = pc_1;
        end
    end

    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus hand
// sequences for halt/resume, stack depth limits and async reset.
module tb_pc_unit;
    import mcu_pkg::*;

`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_addr = 8'h00;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       halt = 1'b0;
    logic       resume = 1'b0;
    logic [7:0] pc;
    logic [7:0] pc_1;
    logic       running;
    logic       stack_ovf;
    logic       stack_unf;

    pc_unit #(
        .RESET_VEC   (8'h00),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .load_addr (load_addr),
        .call      (call),
        .ret       (ret),
        .halt      (halt),
        .resume    (resume),
        .pc        (pc),
        .pc_1      (pc_1),
        .running   (running),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       load;
        logic [7:0] addr;
        logic       call;
        logic       ret;
        logic       halt;
        logic       resume;
        logic [7:0] e_pc;
        logic       e_run;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic       run;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total = 0;

    function automatic vec_t mk(
        input logic e, input logic l, input logic [7:0] a,
        input logic c, input logic r, input logic h,
        input logic rs, input logic [7:0] p, input logic ru,
        input logic o, input logic u);
        vec_t v;
        v.en = e; v.load = l; v.addr = a; v.call = c;
        v.ret = r; v.halt = h; v.resume = rs;
        v.e_pc = p; v.e_run = ru; v.e_ovf = o; v.e_unf = u;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push_exp(input logic [7:0] p, input logic ru,
                            input logic o, input logic u);
        exp_t e;
        e.pc = p; e.run = ru; e.ovf = o; e.unf = u;
        sbq.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".pc"}, pc, e.pc);
            chk({tag, ".pc_1"}, pc_1, e.pc + 8'd1);
            chk({tag, ".running"}, {7'd0, running}, {7'd0, e.run});
            chk({tag, ".ovf"}, {7'd0, stack_ovf}, {7'd0, e.ovf});
            chk({tag, ".unf"}, {7'd0, stack_unf}, {7'd0, e.unf});
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        en = v.en; load = v.load; load_addr = v.addr;
        call = v.call; ret = v.ret; halt = v.halt;
        resume = v.resume;
        push_exp(v.e_pc, v.e_run, v.e_ovf, v.e_unf);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[12];
        logic [7:0] cur;
        logic [7:0] addr;
        logic [7:0] mstk[$];
        logic       movf;
        logic       munf;

        tbl[0]  = mk(1,0,8'h00,0,0,0,0, 8'h00,1,0,0);
        tbl[1]  = mk(1,0,8'h00,0,0,0,0, 8'h01,1,0,0);
        tbl[2]  = mk(1,0,8'h00,0,0,0,0, 8'h02,1,0,0);
        tbl[3]  = mk(0,0,8'h00,0,0,0,0, 8'h02,1,0,0);
        tbl[4]  = mk(1,1,8'h10,0,0,0,0, 8'h10,1,0,0);
        tbl[5]  = mk(1,0,8'h40,1,0,0,0, 8'h40,1,0,0);
        tbl[6]  = mk(1,1,8'h77,0,1,0,0,
                     STK ? 8'h11 : 8'h41,1,0,0);
        tbl[7]  = mk(0,1,8'h99,0,0,0,0,
                     STK ? 8'h11 : 8'h41,1,0,0);
        tbl[8]  = mk(1,1,8'hFF,0,0,0,0, 8'hFF,1,0,0);
        tbl[9]  = mk(1,0,8'h00,0,0,0,0, 8'h00,1,0,0);
        tbl[10] = mk(0,0,8'h33,1,0,0,0, 8'h00,1,0,0);
        tbl[11] = mk(1,0,8'h00,0,0,0,0, 8'h01,1,0,0);

        // reset state
        @(posedge clk);
        #1;
        push_exp(8'h00, 0, 0, 0);
        check("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // halt / resume around pc=20
        step(mk(1,1,8'h20,0,0,0,0, 8'h20,1,0,0), "h_load");
        step(mk(1,1,8'h55,0,0,1,0, 8'h20,0,0,0), "h_enter");
        for (int i = 0; i < 3; i++) begin
            step(mk(i[0],1,8'h66,1,0,0,0, 8'h20,0,0,0),
                 $sformatf("h_hold%0d", i));
        end
        step(mk(1,0,8'h00,0,0,1,1, 8'h20,0,0,0), "h_prio");
        step(mk(1,0,8'h00,0,0,0,1, 8'h20,1,0,0), "h_resume");
        step(mk(1,0,8'h00,0,0,0,0, 8'h21,1,0,0), "h_inc0");
        step(mk(1,0,8'h00,0,0,0,0, 8'h22,1,0,0), "h_inc1");

        // stack depth: 5 calls then 5 rets
        step(mk(1,1,8'h80,0,0,0,0, 8'h80,1,0,0), "s_load");
        cur = 8'h80;
        movf = 1'b0;
        munf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr = 8'hA0 + 8'(16 * i);
            if (STK) begin
                if (mstk.size() < DEPTH) mstk.push_back(cur + 8'd1);
                else movf = 1'b1;
            end
            cur = addr;
            step(mk(1,0,addr,1,0,0,0, cur,1,movf,munf),
                 $sformatf("s_call%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            if (STK && mstk.size() > 0) begin
                cur = mstk.pop_back();
            end else begin
                if (STK) munf = 1'b1;
                cur = cur + 8'd1;
            end
            step(mk(1,1,8'h5A,0,1,0,0, cur,1,movf,munf),
                 $sformatf("s_ret%0d", i));
        end
        step(mk(1,0,8'h00,0,0,0,0, cur + 8'd1,1,movf,munf),
             "s_sticky");

        // async reset in the middle of a call
        @(negedge clk);
        en = 1'b1; call = 1'b1; load_addr = 8'hC3;
        ret = 1'b0; load = 1'b0; halt = 1'b0; resume = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(8'h00, 0, 0, 0);
        check("ar_now");
        @(posedge clk);
        #1;
        push_exp(8'h00, 0, 0, 0);
        check("ar_hold");
        rst_n = 1'b1;
        step(mk(1,0,8'h00,0,0,0,0, 8'h00,1,0,0), "ar_boot");
        step(mk(1,0,8'h00,0,1,0,0, 8'h01,1,0,STK), "ar_empty");
        step(mk(1,0,8'h50,1,0,0,0, 8'h50,1,0,STK), "ar_call");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
